ssd_display_ctrl: RTL and testbench
===================================

# ssd_display_ctrl

Sequencing controller for the two-digit PmodSSD speed readout. It accepts BCD speed digits over a valid/ready handshake and buffers them so digit updates occur only at scan-frame boundaries. It time-multiplexes the two digits onto the shared segment bus and runs the over-speed flash state machine. Its `ssd_o`, `flash_state_o` and `flash_phase_o` outputs drive the segment-flash gate's segment, state and flash-rate inputs.

## Interface
- `SCAN_DIV`, 1000: cycles per digit slot; must be ≥ 2.
- `FLASH_DIV`, 2000000: cycles per flash half-period (bright or dark); must be ≥ 2.
- `ALARM_HOLD`, 3: full flash periods that continue after `alarm_i` falls; must be ≥ 1.
- `clk_i` in 1: system clock. This is the block's only clock.
- `rst_ni` in 1: reset, synchronous and active-low.
- `digits_valid_i` in 1: the new digit pair is valid.
- `tens_i` in 4: BCD tens digit.
- `ones_i` in 4: BCD ones digit.
- `digits_ready_o` out 1: the pending buffer is empty, so a digit pair can be accepted.
- `alarm_i` in 1: over-speed request, level-sensitive.
- `ssd_o` out 7: raw segments, active-low, ordered {g,f,e,d,c,b,a}.
- `digit_sel_o` out 1: digit select. 0 selects ones; 1 selects tens.
- `flash_state_o` out 1: flashing is active.
- `flash_phase_o` out 1: flash phase. 1 is bright; 0 is dark.

## Operation
- **Registers:**
  - `disp_tens` and `disp_ones` hold the digits being shown.
  - `pend_tens`, `pend_ones` and `pend_full` form the one-deep pending buffer.
- **Handshake:**
  - `digits_ready_o` = !`pend_full`.
  - A transfer occurs on any cycle with valid && ready. It loads the pending registers and sets `pend_full`.
  - `digits_valid_i` may be dropped or changed while ready is low; nothing is captured in that case.
- **Commit:**
  - A frame boundary is the cycle where the scan counter is at `SCAN_DIV`-1 and `digit_sel_o`=1.
  - At a frame boundary with `pend_full`=1, the pending digits copy to the display registers and `pend_full` clears.
  - A transfer in that same cycle is impossible, because ready is low.
- **Scan:**
  - The counter runs from 0 to `SCAN_DIV`-1 and then wraps.
  - `digit_sel_o` toggles on each wrap.
- **Decode (active-low):**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Codes 10–15 show a dash, 0111111.
  - Leading-zero suppression: when tens=0, the tens slot shows 1111111.
- **Flash FSM** (the flash counter runs from 0 to `FLASH_DIV`-1; `flash_phase_o` toggles on each wrap):
  - **IDLE:** `flash_state_o`=0, `flash_phase_o`=1, counter held at 0. `alarm_i`=1 moves to FLASH.
  - **FLASH:** `flash_state_o`=1; the phase runs. `alarm_i`=0 moves to HOLD and loads the hold count with `ALARM_HOLD`.
  - **HOLD:** `flash_state_o`=1; the phase keeps running without restart.
    - Each dark→bright toggle decrements the hold count.
    - When the count reaches 0 on a dark→bright toggle, the FSM returns to IDLE. The display therefore always exits bright.
    - `alarm_i`=1 returns the FSM to FLASH with no phase discontinuity.
  - Entering FLASH from IDLE always starts with a full bright half-period.
- **Reset:** asserting `rst_ni` low at any time, including mid-flash or with `pend_full` set, forces every register to its reset value and discards pending digits.

## Timing
- All outputs are registered.
- Reset values:
  - `ssd_o`=1111111, `digit_sel_o`=0, `digits_ready_o`=1
  - `flash_state_o`=0, `flash_phase_o`=1
  - display and pending digits = 0, both counters = 0, FSM = IDLE
- First cycle after reset release: `ssd_o`=1000000 (ones=0), `digit_sel_o`=0.
- `ssd_o` and `digit_sel_o` change on the same edge, so the bus never shows one digit's segments under the other digit's select.
- `digits_ready_o` falls on the edge after a transfer. It rises on the edge after the commit.
- Committed digits first appear in the ones slot starting at the cycle after the frame boundary.
- Worst-case accept-to-display latency is 2·`SCAN_DIV`+1 cycles.
- `alarm_i` rising in IDLE gives `flash_state_o`=1 on the next edge, with `flash_phase_o`=1.
- A dark half-period starts `FLASH_DIV` cycles after entry.
- `flash_state_o` falls exactly `ALARM_HOLD` dark→bright toggles after `alarm_i` falls. This happens on the edge of the final toggle.

## Test plan
- **Reset:** hold `rst_ni`=0 for 5 cycles, then release → `ssd_o`=1111111 while in reset and 1000000 one cycle after release; `digit_sel_o` toggles every `SCAN_DIV` cycles.
- **Digit update:** `SCAN_DIV`=4; send tens=4, ones=7 mid-frame → ready drops the next cycle; after the frame boundary, ones slot=1111000 and tens slot=0011001; ready returns high.
- **Back-pressure and blanking:**
  - Send a pair (tens=2, ones=3), then hold valid with tens=0, ones=5 while ready is low → the second pair is not captured.
  - After the commit and re-accept, the tens slot shows 1111111 and the ones slot shows 0010010.
  - Sending tens=12 → the tens slot shows 0111111.
- **Flash entry:** `FLASH_DIV`=3; pulse `alarm_i` high → state=1, phase=1 for 3 cycles, then 0 for 3 cycles, alternating.
- **Hold and re-trigger:**
  - With `ALARM_HOLD`=2, drop alarm → the state stays 1 for 2 more dark→bright toggles, then goes to 0 with phase=1.
  - Re-asserting alarm during HOLD → the state stays 1 with no phase glitch.
- **Reset mid-operation:** assert reset during FLASH with `pend_full`=1 → next cycle: IDLE, ready=1, display digits=0.

Source files
------------

// File: rtl/ssd_display_ctrl.sv
// Two-digit PmodSSD speed readout controller: frame-synchronous digit buffer,
// digit scan multiplexer with BCD decode, and over-speed flash sequencer.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_IDLE    | no alarm; steady bright display, flash counter parked at 0
// ST_FLASH   | alarm asserted; phase toggles every FLASH_DIV cycles
// ST_HOLD    | alarm released; flashing continues for ALARM_HOLD full periods
module ssd_display_ctrl #(
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned FLASH_DIV  = 2000000,
    parameter int unsigned ALARM_HOLD = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       digits_valid_i,
    input  logic [3:0] tens_i,
    input  logic [3:0] ones_i,
    output logic       digits_ready_o,
    input  logic       alarm_i,
    output logic [6:0] ssd_o,
    output logic       digit_sel_o,
    output logic       flash_state_o,
    output logic       flash_phase_o
);

    localparam int unsigned SCAN_W  = $clog2(SCAN_DIV);
    localparam int unsigned FLASH_W = $clog2(FLASH_DIV);
    localparam int unsigned HOLD_W  = $clog2(ALARM_HOLD + 1);

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_DIV - 1);
    localparam logic [HOLD_W-1:0]  HOLD_INIT  = HOLD_W'(ALARM_HOLD);
    localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FLASH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic               digit_sel_q, digit_sel_d;
    logic [3:0]         disp_tens_q, disp_tens_d;
    logic [3:0]         disp_ones_q, disp_ones_d;
    logic [3:0]         pend_tens_q, pend_tens_d;
    logic [3:0]         pend_ones_q, pend_ones_d;
    logic               pend_full_q, pend_full_d;
    logic [6:0]         ssd_q, ssd_d;

    logic [1:0]         state_q, state_d;
    logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
    logic               flash_phase_q, flash_phase_d;
    logic               flash_state_q, flash_state_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;

    logic scan_wrap;
    logic frame_end;
    logic xfer;
    logic commit;
    logic flash_wrap;
    logic dark_to_bright;

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

    function automatic logic [6:0] seg_tens(input logic [3:0] d);
        return (d == 4'd0) ? SEG_BLANK : seg_digit(d);
    endfunction

    // Scan, buffer and decode; segments are computed from the next-state
    // select and digits so bus and select always switch on the same edge.
    always_comb begin
        scan_wrap   = (scan_cnt_q == SCAN_LAST);
        frame_end   = scan_wrap && digit_sel_q;
        xfer        = digits_valid_i && !pend_full_q;
        commit      = frame_end && pend_full_q;

        scan_cnt_d  = scan_wrap ? '0 : scan_cnt_q + SCAN_W'(1);
        digit_sel_d = scan_wrap ? ~digit_sel_q : digit_sel_q;

        disp_tens_d = disp_tens_q;
        disp_ones_d = disp_ones_q;
        pend_tens_d = pend_tens_q;
        pend_ones_d = pend_ones_q;
        pend_full_d = pend_full_q;

        if (commit) begin
            disp_tens_d = pend_tens_q;
            disp_ones_d = pend_ones_q;
            pend_full_d = 1'b0;
        end
        if (xfer) begin
            pend_tens_d = tens_i;
            pend_ones_d = ones_i;
            pend_full_d = 1'b1;
        end

        ssd_d = digit_sel_d ? seg_tens(disp_tens_d) : seg_digit(disp_ones_d);
    end

    always_comb begin
        flash_wrap     = (flash_cnt_q == FLASH_LAST);
        dark_to_bright = flash_wrap && !flash_phase_q;

        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        flash_cnt_d   = flash_wrap ? '0 : flash_cnt_q + FLASH_W'(1);
        flash_phase_d = flash_wrap ? ~flash_phase_q : flash_phase_q;

        unique case (state_q)
            ST_IDLE: begin
                flash_cnt_d   = '0;
                flash_phase_d = 1'b1;
                if (alarm_i) state_d = ST_FLASH;
            end
            ST_FLASH: begin
                if (!alarm_i) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = HOLD_INIT;
                end
            end
            ST_HOLD: begin
                if (alarm_i) begin
                    state_d = ST_FLASH;
                end else if (dark_to_bright) begin
                    if (hold_cnt_q == HOLD_ONE) begin
                        state_d     = ST_IDLE;
                        flash_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q - HOLD_ONE;
                    end
                end
            end
            default: begin
                state_d       = ST_IDLE;
                flash_cnt_d   = '0;
                flash_phase_d = 1'b1;
            end
        endcase

        flash_state_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            scan_cnt_q    <= '0;
            digit_sel_q   <= 1'b0;
            disp_tens_q   <= 4'd0;
            disp_ones_q   <= 4'd0;
            pend_tens_q   <= 4'd0;
            pend_ones_q   <= 4'd0;
            pend_full_q   <= 1'b0;
            ssd_q         <= SEG_BLANK;
            state_q       <= ST_IDLE;
            flash_cnt_q   <= '0;
            flash_phase_q <= 1'b1;
            flash_state_q <= 1'b0;
            hold_cnt_q    <= '0;
        end else begin
            scan_cnt_q    <= scan_cnt_d;
            digit_sel_q   <= digit_sel_d;
            disp_tens_q   <= disp_tens_d;
            disp_ones_q   <= disp_ones_d;
            pend_tens_q   <= pend_tens_d;
            pend_ones_q   <= pend_ones_d;
            pend_full_q   <= pend_full_d;
            ssd_q         <= ssd_d;
            state_q       <= state_d;
            flash_cnt_q   <= flash_cnt_d;
            flash_phase_q <= flash_phase_d;
            flash_state_q <= flash_state_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    assign digits_ready_o = !pend_full_q;
    assign ssd_o          = ssd_q;
    assign digit_sel_o    = digit_sel_q;
    assign flash_state_o  = flash_state_q;
    assign flash_phase_o  = flash_phase_q;

endmodule

// File: tb/tb_ssd_display_ctrl.sv
// Directed bench for ssd_display_ctrl with short scan/flash dividers; the
// step comments track the number of clock edges since reset release.
module tb_ssd_display_ctrl;

    logic       clk;
    logic       rst_n;
    logic       valid;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       ready;
    logic       alarm;
    logic [6:0] ssd;
    logic       sel;
    logic       fstate;
    logic       fphase;

    int n_chk  = 0;
    int n_fail = 0;

    ssd_display_ctrl #(
        .SCAN_DIV  (4),
        .FLASH_DIV (3),
        .ALARM_HOLD(2)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .digits_valid_i(valid),
        .tens_i        (tens),
        .ones_i        (ones),
        .digits_ready_o(ready),
        .alarm_i       (alarm),
        .ssd_o         (ssd),
        .digit_sel_o   (sel),
        .flash_state_o (fstate),
        .flash_phase_o (fphase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        tens  = 4'd0;
        ones  = 4'd0;
        alarm = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_ssd",    32'(ssd),    32'h7F);
        chk("rst_sel",    32'(sel),    32'h0);
        chk("rst_ready",  32'(ready),  32'h1);
        chk("rst_fstate", 32'(fstate), 32'h0);
        chk("rst_fphase", 32'(fphase), 32'h1);

        rst_n = 1'b1;
        step(1); // k1
        chk("rel_ssd", 32'(ssd), 32'h40);
        chk("rel_sel", 32'(sel), 32'h0);
        step(3); // k4
        chk("scan1_sel", 32'(sel), 32'h1);
        chk("scan1_ssd", 32'(ssd), 32'h7F);
        step(4); // k8
        chk("scan2_sel", 32'(sel), 32'h0);
        chk("scan2_ssd", 32'(ssd), 32'h40);

        step(1); // k9
        chk("upd_ready_pre", 32'(ready), 32'h1);
        valid = 1'b1; tens = 4'd4; ones = 4'd7;
        step(1); // k10
        chk("upd_ready_drop", 32'(ready), 32'h0);
        valid = 1'b0;
        step(5); // k15
        chk("upd_ready_wait", 32'(ready), 32'h0);
        step(1); // k16
        chk("upd_ready_back", 32'(ready), 32'h1);
        chk("upd_sel_ones",   32'(sel),   32'h0);
        chk("upd_ones7",      32'(ssd),   32'h78);
        step(4); // k20
        chk("upd_sel_tens", 32'(sel), 32'h1);
        chk("upd_tens4",    32'(ssd), 32'h19);

        valid = 1'b1; tens = 4'd2; ones = 4'd3;
        step(1); // k21
        chk("bp_ready_low", 32'(ready), 32'h0);
        tens = 4'd0; ones = 4'd5;
        step(3); // k24
        chk("bp_ones3",  32'(ssd),   32'h30);
        chk("bp_commit", 32'(ready), 32'h1);
        step(1); // k25
        chk("bp_reaccept", 32'(ready), 32'h0);
        valid = 1'b0;
        step(3); // k28
        chk("bp_tens2", 32'(ssd), 32'h24);
        step(4); // k32
        chk("bp_ones5",  32'(ssd),   32'h12);
        chk("bp_ready2", 32'(ready), 32'h1);
        step(4); // k36
        chk("bp_blank", 32'(ssd), 32'h7F);

        valid = 1'b1; tens = 4'd12; ones = 4'd9;
        step(1); // k37
        chk("dash_ready", 32'(ready), 32'h0);
        valid = 1'b0;
        step(3); // k40
        chk("dash_ones9", 32'(ssd), 32'h10);
        step(4); // k44
        chk("dash_tens", 32'(ssd),    32'h3F);
        chk("pre_fstate", 32'(fstate), 32'h0);
        chk("pre_fphase", 32'(fphase), 32'h1);

        alarm = 1'b1;
        step(1); // k45
        chk("fl_entry_state", 32'(fstate), 32'h1);
        chk("fl_entry_phase", 32'(fphase), 32'h1);
        step(2); // k47
        chk("fl_bright3", 32'(fphase), 32'h1);
        step(1); // k48
        chk("fl_dark1", 32'(fphase), 32'h0);
        step(2); // k50
        chk("fl_dark3", 32'(fphase), 32'h0);
        step(1); // k51
        chk("fl_bright_again", 32'(fphase), 32'h1);

        alarm = 1'b0;
        step(5); // k56
        chk("hold_state_a", 32'(fstate), 32'h1);
        chk("hold_dark_a",  32'(fphase), 32'h0);
        step(1); // k57
        chk("hold_state_b",  32'(fstate), 32'h1);
        chk("hold_bright_b", 32'(fphase), 32'h1);
        step(5); // k62
        chk("hold_state_c", 32'(fstate), 32'h1);
        chk("hold_dark_c",  32'(fphase), 32'h0);
        step(1); // k63
        chk("hold_exit_state", 32'(fstate), 32'h0);
        chk("hold_exit_phase", 32'(fphase), 32'h1);
        step(1); // k64
        chk("idle_state", 32'(fstate), 32'h0);
        chk("idle_phase", 32'(fphase), 32'h1);

        alarm = 1'b1;
        step(1); // k65
        chk("rt_entry", 32'(fstate), 32'h1);
        alarm = 1'b0;
        step(3); // k68
        chk("rt_dark", 32'(fphase), 32'h0);
        step(3); // k71
        chk("rt_bright",      32'(fphase), 32'h1);
        chk("rt_state_hold",  32'(fstate), 32'h1);
        step(1); // k72
        alarm = 1'b1;
        step(2); // k74
        chk("rt_state_a", 32'(fstate), 32'h1);
        chk("rt_phase_a", 32'(fphase), 32'h0);
        step(3); // k77
        chk("rt_state_b", 32'(fstate), 32'h1);
        chk("rt_phase_b", 32'(fphase), 32'h1);
        step(3); // k80
        chk("rt_state_c", 32'(fstate), 32'h1);
        chk("rt_phase_c", 32'(fphase), 32'h0);

        valid = 1'b1; tens = 4'd3; ones = 4'd8;
        step(1); // k81
        chk("mr_pend", 32'(ready), 32'h0);
        valid = 1'b0;
        alarm = 1'b0;
        rst_n = 1'b0;
        step(1);
        chk("mr_fstate", 32'(fstate), 32'h0);
        chk("mr_fphase", 32'(fphase), 32'h1);
        chk("mr_ready",  32'(ready),  32'h1);
        chk("mr_ssd",    32'(ssd),    32'h7F);
        chk("mr_sel",    32'(sel),    32'h0);
        rst_n = 1'b1;
        step(1);
        chk("mr_ones0", 32'(ssd), 32'h40);
        step(3);
        chk("mr_tens_blank", 32'(ssd), 32'h7F);
        step(4);
        chk("mr_discard_ones", 32'(ssd),   32'h40);
        chk("mr_discard_rdy",  32'(ready), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
